clk_div_monitor: RTL

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 20 ++
 rtl/clk_div_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding
// and the bit positions inside err_sticky.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } mon_state_t;

  localparam int ERR_RANGE   = 0;  // measured period outside [PERIOD_MIN, PERIOD_MAX]
  localparam int ERR_TIMEOUT = 1;  // no edge seen for TIMEOUT cycles

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a history flop; flags the rising edge of an
// asynchronous input as a one-cycle pulse in the clk domain.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh;  // sh[0], sh[1]: synchronizer, sh[2]: previous synchronized value

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], async_in};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in reference-clock cycles, locks
// after LOCK_CNT consecutive in-range periods and records range / timeout
// errors in sticky flags.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PERIOD_MIN = 2,
  parameter int PERIOD_MAX = 4,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             en,
  input  logic             err_clr,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [1:0]       err_sticky
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  P_MIN  = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0]  P_MAX  = CNT_W'(PERIOD_MAX);
  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_CNT);

  mon_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              rise;

  logic              in_range;
  logic              tmo;
  logic [CNT_W-1:0]  cnt_inc;
  logic [GOOD_W-1:0] good_inc;
  logic [1:0]        err_new;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (mon_clk),
    .rise     (rise)
  );

  assign in_range = (cnt >= P_MIN) && (cnt <= P_MAX);
  assign tmo      = (cnt == TMO);
  assign cnt_inc  = tmo ? cnt : cnt + 1'b1;
  assign good_inc = (good_cnt == LOCK_V) ? good_cnt : good_cnt + 1'b1;

  // New error events this cycle; an edge always pre-empts a timeout
  always_comb begin
    err_new = 2'b00;
    if (en && state != ST_IDLE) begin
      if (rise) begin
        if (state != ST_ACQUIRE && !in_range) err_new[ERR_RANGE] = 1'b1;
      end else if (tmo) begin
        err_new[ERR_TIMEOUT] = 1'b1;
      end
    end
  end

  // Monitor FSM with period counter, lock counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_sticky   <= 2'b00;
    end else begin
      period_valid <= 1'b0;
      // a clear drops old flags but never hides an error raised this cycle
      err_sticky   <= (err_clr ? 2'b00 : err_sticky) | err_new;
      if (!en) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ACQUIRE;
            cnt   <= CNT_W'(1);
          end
          ST_ACQUIRE: begin
            if (rise) begin
              state    <= ST_CHECK;
              cnt      <= CNT_W'(1);
              good_cnt <= '0;
            end else if (tmo) begin
              cnt <= CNT_W'(1);
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_CHECK, ST_LOCKED: begin
            if (rise) begin
              cnt          <= CNT_W'(1);
              period       <= cnt;
              period_valid <= 1'b1;
              if (in_range) begin
                good_cnt <= good_inc;
                if (state == ST_CHECK && good_inc == LOCK_V) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
                state    <= ST_CHECK;
                locked   <= 1'b0;
              end
            end else if (tmo) begin
              state    <= ST_ACQUIRE;
              cnt      <= CNT_W'(1);
              good_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
